// File: rtl/muldiv_iter.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, STEP bits per cycle.
// Optional MULDIV_EARLY_OUT_EN: zero-divisor, signed-overflow and zero-operand ops skip CALC/FIX.
module muldiv_iter #(
   parameter int WIDTH = 64,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             word,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] N_FULL = CW'(WIDTH / STEP);
   localparam logic [CW-1:0] N_WORD = CW'(WIDTH / 2 / STEP);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic WORD_OK = (WIDTH == 64);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_r, state_nxt_s, state_tmp_s;
   logic [2:0]         op_r;
   logic               word_r, neg_r, rneg_r, div_zero_r, out_valid_r;
   logic [WIDTH-1:0]   acc_r, lo_r, opnd_r, result_r;
   logic [CW-1:0]      cnt_r;

   logic               word_s, is_div_s, a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, div_zero_s, accept_s;
   logic [WIDTH-1:0]   a_ext_s, b_ext_s, a_abs_s, b_abs_s;
   logic [WIDTH-1:0]   it_acc_s, it_lo_s;
   logic [WIDTH:0]     sum_s, sh_s, diff_s;
   logic [2*WIDTH-1:0] prod_s, prod_fix_s;
   logic [WIDTH-1:0]   quo_s, rem_s, raw_s, fix_res_s;
   logic               early_s;
   logic [WIDTH-1:0]   early_res_s;

   // Replace bits above 31 with (sgn & bit 31).
   function automatic logic [WIDTH-1:0] ext32(input logic [WIDTH-1:0] x, input logic sgn);
      logic [WIDTH-1:0] r;
      r = x;
      for (int i = 32; i < WIDTH; i++) begin
         r[i] = sgn & x[31];
      end
      return r;
   endfunction

   // Accept-time operand decode: extension, sign, magnitude.
   always_comb begin
      word_s   = WORD_OK ? word : 1'b0;
      is_div_s = op[2];
      a_sgn_s  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      b_sgn_s  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      a_ext_s  = word_s ? ext32(a, a_sgn_s) : a;
      b_ext_s  = word_s ? ext32(b, b_sgn_s) : b;
      a_neg_s  = a_sgn_s & a_ext_s[WIDTH-1];
      b_neg_s  = b_sgn_s & b_ext_s[WIDTH-1];
      a_abs_s  = a_neg_s ? -a_ext_s : a_ext_s;
      b_abs_s  = b_neg_s ? -b_ext_s : b_ext_s;
      div_zero_s = is_div_s && (b_ext_s == {WIDTH{1'b0}});
   end

`ifdef MULDIV_EARLY_OUT_EN
   localparam logic [WIDTH-1:0] MIN_FULL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MIN_WORD = WIDTH'(32'h8000_0000);
   logic ovf_s, mul_zero_s;

   // Results known at accept time (overflow quotient is a itself).
   always_comb begin
      ovf_s = is_div_s && b_sgn_s && a_neg_s &&
              (a_abs_s == (word_s ? MIN_WORD : MIN_FULL)) && (b_ext_s == {WIDTH{1'b1}});
      mul_zero_s = !is_div_s && ((a_ext_s == {WIDTH{1'b0}}) || (b_ext_s == {WIDTH{1'b0}}));
      early_s = div_zero_s || ovf_s || mul_zero_s;
      if (div_zero_s) begin
         early_res_s = op[1] ? (word_s ? ext32(a, 1'b1) : a) : {WIDTH{1'b1}};
      end else if (ovf_s) begin
         early_res_s = op[1] ? {WIDTH{1'b0}} : a_ext_s;
      end else begin
         early_res_s = {WIDTH{1'b0}};
      end
   end
`else
   assign early_s     = 1'b0;
   assign early_res_s = {WIDTH{1'b0}};
`endif

   assign accept_s = (state_r == S_IDLE) && in_valid && !flush;

   // STEP iterations of shift-add multiply or restoring divide.
   always_comb begin
      it_acc_s = acc_r;
      it_lo_s  = lo_r;
      sum_s    = {(WIDTH+1){1'b0}};
      sh_s     = {(WIDTH+1){1'b0}};
      diff_s   = {(WIDTH+1){1'b0}};
      for (int i = 0; i < STEP; i++) begin
         if (op_r[2]) begin
            sh_s    = {it_acc_s, it_lo_s[WIDTH-1]};
            diff_s  = sh_s - {1'b0, opnd_r};
            if (!diff_s[WIDTH]) begin
               it_acc_s = diff_s[WIDTH-1:0];
               it_lo_s  = {it_lo_s[WIDTH-2:0], 1'b1};
            end else begin
               it_acc_s = sh_s[WIDTH-1:0];
               it_lo_s  = {it_lo_s[WIDTH-2:0], 1'b0};
            end
         end else begin
            sum_s    = {1'b0, it_acc_s} + {1'b0, (it_lo_s[0] ? opnd_r : {WIDTH{1'b0}})};
            it_lo_s  = {sum_s[0], it_lo_s[WIDTH-1:1]};
            it_acc_s = sum_s[WIDTH:1];
         end
      end
   end

   // Sign fix-up and result selection; word-form products sit WIDTH/2 bits up.
   always_comb begin
      prod_s     = {acc_r, lo_r};
      prod_fix_s = neg_r ? -prod_s : prod_s;
      quo_s      = div_zero_r ? {WIDTH{1'b1}} : (neg_r ? -lo_r : lo_r);
      rem_s      = rneg_r ? -acc_r : acc_r;
      case (op_r)
         OP_MUL:                      raw_s = word_r ? prod_fix_s[WIDTH/2 +: WIDTH] : prod_fix_s[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: raw_s = prod_fix_s[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:             raw_s = quo_s;
         OP_REM, OP_REMU:             raw_s = rem_s;
         default:                     raw_s = {WIDTH{1'b0}};
      endcase
      fix_res_s = word_r ? ext32(raw_s, 1'b1) : raw_s;
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_tmp_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (in_valid) begin
               state_tmp_s = early_s ? S_DONE : S_CALC;
            end else begin
               state_tmp_s = S_IDLE;
            end
         end
         S_CALC: begin
            if (cnt_r == ONE_C) begin
               state_tmp_s = S_FIX;
            end else begin
               state_tmp_s = S_CALC;
            end
         end
         S_FIX:  state_tmp_s = S_DONE;
         S_DONE: begin
            if (out_ready) begin
               state_tmp_s = S_IDLE;
            end else begin
               state_tmp_s = S_DONE;
            end
         end
         default: state_tmp_s = S_IDLE;
      endcase
      state_nxt_s = flush ? S_IDLE : state_tmp_s;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand latch, iteration registers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r        <= 3'd0;
         word_r      <= 1'b0;
         neg_r       <= 1'b0;
         rneg_r      <= 1'b0;
         div_zero_r  <= 1'b0;
         acc_r       <= {WIDTH{1'b0}};
         lo_r        <= {WIDTH{1'b0}};
         opnd_r      <= {WIDTH{1'b0}};
         cnt_r       <= {CW{1'b0}};
         result_r    <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         if (accept_s) begin
            op_r       <= op;
            word_r     <= word_s;
            neg_r      <= a_neg_s ^ b_neg_s;
            rneg_r     <= a_neg_s;
            div_zero_r <= div_zero_s;
            acc_r      <= {WIDTH{1'b0}};
            cnt_r      <= word_s ? N_WORD : N_FULL;
            if (is_div_s) begin
               opnd_r <= b_abs_s;
               lo_r   <= word_s ? (a_abs_s << (WIDTH/2)) : a_abs_s;
            end else begin
               opnd_r <= a_abs_s;
               lo_r   <= b_abs_s;
            end
         end else if (state_r == S_CALC) begin
            acc_r <= it_acc_s;
            lo_r  <= it_lo_s;
            cnt_r <= cnt_r - ONE_C;
         end
         if (accept_s && early_s) begin
            result_r <= early_res_s;
         end else if ((state_r == S_FIX) && !flush) begin
            result_r <= fix_res_s;
         end
         out_valid_r <= (state_nxt_s == S_DONE);
      end
   end

   assign in_ready  = (state_r == S_IDLE);
   assign busy      = (state_r != S_IDLE);
   assign out_valid = out_valid_r;
   assign result    = result_r;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter (WIDTH=64, STEP=1): vector table plus handshake/flush/reset sequences.
module tb_muldiv_iter;
   logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, word = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic        in_ready, busy, out_valid;
   logic [2:0]  op = 3'd0;
   logic [63:0] a = 64'd0, b = 64'd0, result;
   int          tests = 0, fails = 0;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   muldiv_iter #(.WIDTH(64), .STEP(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .word(word),
      .a(a), .b(b), .flush(flush), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .result(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic        word;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
      bit          early;
   } vec_t;
   vec_t vecs[19];

   task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // Offer one op; lat counts edges with the accept edge as edge 1.
   task automatic do_op(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y,
                        output logic [63:0] r, output int lat);
      @(negedge clk);
      op = o; word = w; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      r = result;
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] r;
      int lat, exp_lat, seen;

      vecs[0]  = '{3'd0, 1'b0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, 1'b0};
      vecs[1]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1'b0};
      vecs[2]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 66, 1'b0};
      vecs[3]  = '{3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 34, 1'b1};
      vecs[4]  = '{3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 34, 1'b1};
      vecs[5]  = '{3'd5, 1'b0, 64'h5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b1};
      vecs[6]  = '{3'd7, 1'b0, 64'h5, 64'h0, 64'h5, 66, 1'b1};
      vecs[7]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b0};
      vecs[8]  = '{3'd4, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 66, 1'b0};
      vecs[9]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1'b0};
      vecs[10] = '{3'd5, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_0000_0007, 64'hE, 34, 1'b0};
      vecs[11] = '{3'd0, 1'b1, 64'h5555_5555_0000_FFFF, 64'h0001_0001, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b0};
      vecs[12] = '{3'd7, 1'b1, 64'hFFFF_FFFF, 64'd10, 64'h5, 34, 1'b0};
      vecs[13] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 66, 1'b1};
      vecs[14] = '{3'd6, 1'b1, 64'h8000_0005, 64'h0, 64'hFFFF_FFFF_8000_0005, 34, 1'b1};
      vecs[15] = '{3'd3, 1'b0, 64'h0, 64'd123, 64'h0, 66, 1'b1};
      vecs[16] = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b1};
      vecs[17] = '{3'd1, 1'b0, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b0};
      vecs[18] = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 66, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      check64("rst_in_ready", 64'(in_ready), 64'd1);
      check64("rst_busy", 64'(busy), 64'd0);
      check64("rst_out_valid", 64'(out_valid), 64'd0);
      check64("rst_result", result, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // flush blocks an accept in the same cycle
      @(negedge clk);
      op = 3'd5; word = 1'b0; a = 64'd9; b = 64'd3; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check64("flush_blocks_accept", 64'(busy), 64'd0);

      for (int i = 0; i < 19; i++) begin
         check64($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
         do_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, r, lat);
         exp_lat = (EARLY && vecs[i].early) ? 1 : vecs[i].lat;
         check64($sformatf("vec%0d_result", i), r, vecs[i].exp);
         check64($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat));
         consume();
         check64($sformatf("vec%0d_idle_after", i), 64'(in_ready), 64'd1);
      end

      // result held while consumer stalls
      do_op(3'd5, 1'b0, 64'd100, 64'd7, r, lat);
      check64("hold_first", r, 64'd14);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check64($sformatf("hold%0d_result", i), result, 64'd14);
         check64($sformatf("hold%0d_in_ready", i), 64'(in_ready), 64'd0);
      end
      consume();
      check64("hold_release_in_ready", 64'(in_ready), 64'd1);
      check64("hold_release_out_valid", 64'(out_valid), 64'd0);

      // flush at cycle 20 of a DIV
      @(negedge clk);
      op = 3'd4; word = 1'b0; a = 64'd1000; b = 64'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check64("flush_accepted", 64'(busy), 64'd1);
      repeat (18) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check64("flush_idle", 64'(busy), 64'd0);
      seen = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      check64("flush_no_out_valid", 64'(seen), 64'd0);

      // asynchronous reset during CALC
      @(negedge clk);
      op = 3'd5; word = 1'b0; a = 64'd100; b = 64'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check64("areset_busy", 64'(busy), 64'd0);
      check64("areset_out_valid", 64'(out_valid), 64'd0);
      check64("areset_result", result, 64'd0);
      check64("areset_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;

      do_op(3'd0, 1'b0, 64'd3, 64'd5, r, lat);
      check64("recover_result", r, 64'd15);
      check64("recover_latency", 64'(lat), 64'd66);
      consume();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit for the execute stage, covering the full RV64M operation set including high-half multiplies and 32-bit word forms. It accepts one operation at a time over a valid/ready handshake, computes `STEP` quotient or product bits per cycle, and holds the result until the consumer takes it. A pipeline flush aborts an operation in flight. The execute stage stalls on `busy` and `!out_valid`.

## Interface
- `WIDTH`, 64: operand and result width; must be 32 or 64.
- `STEP`, 1: bits processed per iteration cycle; must divide `WIDTH/2`; legal values 1, 2, 4.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: unit can accept.
- `op` in 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `word` in 1: 32-bit form; legal only when `WIDTH`=64 and `op` ∈ {0,4,5,6,7}.
- `a`, `b` in `WIDTH`: operands; `b` is the divisor for division ops.
- `flush` in 1: abort the current operation.
- `busy` out 1: an operation is accepted and not yet consumed.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `result` out `WIDTH`: final value.

## Operation
- State machine:
  - IDLE → CALC on accept (`in_valid && in_ready && !flush`).
  - CALC → FIX after N iterations.
  - FIX → DONE.
  - DONE → IDLE on `out_valid && out_ready`.
- N = `WIDTH/STEP`, or `WIDTH/2/STEP` when `word`=1.
- Operands, `op` and `word` are latched at accept. Signed ops take absolute values at accept, and the sign is fixed up in FIX.
- Word mode uses `a[31:0]` and `b[31:0]`, sign- or zero-extended as the op requires. The 32-bit result is sign-extended to `WIDTH`.
- Multiply is shift-add over a 2·`WIDTH` product.
  - MUL returns the low half.
  - MULH returns the high half, signed×signed.
  - MULHSU returns the high half, signed×unsigned.
  - MULHU returns the high half, unsigned×unsigned.
- Divide is restoring, with `STEP` quotient bits per cycle. Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Divisor zero: quotient is all ones, remainder = `a` (in word form, the 32-bit `a` sign-extended).
- Signed overflow (most-negative ÷ −1, at the active width): quotient = most-negative value, remainder = 0.
- `flush` in any state returns the unit to IDLE at the next edge. The aborted result is never presented. `flush` also blocks an accept in the same cycle.

## Timing
- Reset values: state IDLE, `in_ready`=1, `busy`=0, `out_valid`=0, `result`=0, all internal registers 0.
- `in_ready` = (state==IDLE), combinational from state only.
- `busy` = (state!=IDLE).
- Latency: after the accept edge, the unit spends N cycles in CALC and 1 in FIX. `out_valid` rises at the (N+2)th edge after accept: 66 edges for 64-bit with `STEP`=1, 34 edges for word form.
- `result` is registered. It stays stable while `out_valid`=1 and `out_ready`=0, for any number of cycles.
- After the output handshake the unit returns to IDLE. The next accept is possible one cycle later, so back-to-back operations have a 1-cycle gap.
- When `reset` is asserted mid-operation, outputs take their reset values immediately (asynchronously).
- If `flush` and `out_ready` are both high in DONE, the flush wins and no handshake is counted.

## Configuration
- `MULDIV_EARLY_OUT_EN`:
  - Defined: a divide with divisor zero or signed overflow skips CALC and FIX and goes IDLE → DONE. `out_valid` rises at the 1st edge after accept. A multiply with either operand zero behaves the same way, with `result`=0.
  - Undefined: every operation takes the full N+2 latency. Values are identical in both builds; only timing differs.

## Test plan
- MUL, `a`=7, `b`=−3, `WIDTH`=64, `STEP`=1 → `result`=0xFFFF_FFFF_FFFF_FFEB; `out_valid` at edge 66 after accept.
- MULHU, `a`=`b`=0xFFFF_FFFF_FFFF_FFFF → `result`=0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → 0.
- DIV with word=1, `a`=0x8000_0000, `b`=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000. REM with the same operands → 0.
- DIVU, `b`=0, `a`=5 → all ones. REMU → 5. Check early-out latency of 1 edge with the macro defined and 66 edges without it.
- Hold `out_ready` low for 10 cycles after `out_valid` → `result` stable and `in_ready`=0 throughout. Then raise `out_ready` → `in_ready`=1 on the next cycle.
- Assert `flush` at cycle 20 of a DIV → IDLE next edge, `out_valid` never rises. Assert `reset` during CALC → `busy`=0 and `out_valid`=0 immediately.
